// File: rtl/alu_share_arb.sv
// Round-robin arbiter that time-shares one combinational ALU between two
// requesters. It registers the winner's operands and returns a tagged response.
module alu_share_arb #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_x,
  input  logic [WIDTH-1:0] r0_y,
  input  logic [3:0]       r0_op,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_x,
  input  logic [WIDTH-1:0] r1_y,
  input  logic [3:0]       r1_op,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_z,
  input  logic             alu_equal,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_equal,
  output logic             rsp_overflow,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and ready is only offered in IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last;
  logic [WIDTH-1:0] r_alu_x;
  logic [WIDTH-1:0] r_alu_y;
  logic [3:0]       r_alu_op;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_z;
  logic             r_rsp_equal;
  logic             r_rsp_overflow;
  logic             r_rsp_zero;
  logic             r_rsp_err;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;
  logic w_acc0;
  logic w_acc1;
  logic w_illegal;

  // Under contention the requester that was not served last wins.
  assign w_idle   = (r_state == S_IDLE);
  assign w_grant0 = r0_valid && (!r1_valid || r_last);
  assign w_grant1 = r1_valid && (!r0_valid || !r_last);
  assign r0_ready = w_idle && w_grant0;
  assign r1_ready = w_idle && w_grant1;
  assign w_acc0   = r0_valid && r0_ready;
  assign w_acc1   = r1_valid && r1_ready;

  assign w_illegal = (r_alu_op == 4'b0100) || (r_alu_op >= 4'b1011);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_acc0 || w_acc1) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_last         <= 1'b1;
      r_alu_x        <= '0;
      r_alu_y        <= '0;
      r_alu_op       <= '0;
      r_rsp_id       <= 1'b0;
      r_rsp_z        <= '0;
      r_rsp_equal    <= 1'b0;
      r_rsp_overflow <= 1'b0;
      r_rsp_zero     <= 1'b0;
      r_rsp_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc0 || w_acc1) begin
        r_alu_x  <= w_acc1 ? r1_x  : r0_x;
        r_alu_y  <= w_acc1 ? r1_y  : r0_y;
        r_alu_op <= w_acc1 ? r1_op : r0_op;
        r_rsp_id <= w_acc1;
        r_last   <= w_acc1;
      end
      // The ALU has had the whole EXEC cycle to settle on the registered operands.
      if (r_state == S_EXEC) begin
        r_rsp_z        <= alu_z;
        r_rsp_equal    <= alu_equal;
        r_rsp_overflow <= alu_overflow;
        r_rsp_zero     <= alu_zero;
        r_rsp_err      <= w_illegal;
      end
    end
  end

  assign alu_x        = r_alu_x;
  assign alu_y        = r_alu_y;
  assign alu_op       = r_alu_op;
  assign rsp_valid    = (r_state == S_RESP);
  assign rsp_id       = r_rsp_id;
  assign rsp_z        = r_rsp_z;
  assign rsp_equal    = r_rsp_equal;
  assign rsp_overflow = r_rsp_overflow;
  assign rsp_zero     = r_rsp_zero;
  assign rsp_err      = r_rsp_err;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: a behavioural ALU model, table-driven single requests,
// hand sequences for contention, back-pressure and reset, and a response scoreboard.
module tb_alu_share_arb;
  localparam int W  = 32;
  localparam int EW = W + 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         r0_valid = 1'b0, r1_valid = 1'b0;
  logic         r0_ready, r1_ready;
  logic [W-1:0] r0_x = '0, r0_y = '0, r1_x = '0, r1_y = '0;
  logic [3:0]   r0_op = '0, r1_op = '0;
  logic [W-1:0] alu_x, alu_y, alu_z;
  logic [3:0]   alu_op;
  logic         alu_equal, alu_overflow, alu_zero;
  logic         rsp_valid, rsp_id, rsp_equal, rsp_overflow, rsp_zero, rsp_err;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_z;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  bit tb_last;

  typedef struct packed {
    bit           id;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [3:0]   op;
    logic [W-1:0] ez;
    bit           eeq;
    bit           eov;
    bit           ezero;
    bit           eerr;
  } vec_t;

  vec_t vecs[10];

  alu_share_arb #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_x(r0_x), .r0_y(r0_y), .r0_op(r0_op),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_x(r1_x), .r1_y(r1_y), .r1_op(r1_op),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_z(alu_z),
    .alu_equal(alu_equal), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .rsp_equal(rsp_equal), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: returns {z, equal, overflow, zero}; unassigned op codes give 0.
  function automatic logic [W+2:0] alu_ref(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [3:0] op);
    logic [W-1:0] z;
    logic ov;
    z  = '0;
    ov = 1'b0;
    case (op)
      4'b0000: z = x & y;
      4'b0001: z = x | y;
      4'b0010: z = x ^ y;
      4'b0011: z = ~(x | y);
      4'b0101: begin z = x + y; ov = (x[W-1] == y[W-1]) && (z[W-1] != x[W-1]); end
      4'b0110: begin z = x - y; ov = (x[W-1] != y[W-1]) && (z[W-1] != x[W-1]); end
      4'b0111: z = {{(W-1){1'b0}}, ($signed(x) < $signed(y))};
      4'b1000: z = x << y[4:0];
      4'b1001: z = x >> y[4:0];
      4'b1010: z = $unsigned($signed(x) >>> y[4:0]);
      default: z = '0;
    endcase
    return {z, (x == y), ov, (z == '0)};
  endfunction

  always_comb {alu_z, alu_equal, alu_overflow, alu_zero} = alu_ref(alu_x, alu_y, alu_op);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit id, input logic [W-1:0] z, input bit eq, input bit ov,
                          input bit zero, input bit err);
    exp_q.push_back({id, z, eq, ov, zero, err});
  endtask

  task automatic drive_req(input bit id, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [3:0] op);
    if (id) begin r1_valid = 1'b1; r1_x = x; r1_y = y; r1_op = op; end
    else    begin r0_valid = 1'b1; r0_x = x; r0_y = y; r0_op = op; end
  endtask

  // Scoreboard: every completed response handshake is checked against the queue head.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rsp_unexpected: got response id=%0d z=%0h, required none pending",
                 rsp_id, rsp_z);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_fields", {rsp_id, rsp_z, rsp_equal, rsp_overflow, rsp_zero, rsp_err}, mon_e);
      end
    end
  end

  // Single uncontended request with rsp_ready high: accept, EXEC, RESP, back to IDLE.
  task automatic run_single(input vec_t v);
    drive_req(v.id, v.x, v.y, v.op);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("grant_r0", r0_ready, v.id == 1'b0);
    chk("grant_r1", r1_ready, v.id == 1'b1);
    push_exp(v.id, v.ez, v.eeq, v.eov, v.ezero, v.eerr);
    tb_last = v.id;
    @(posedge clk); #1;
    if (v.id) r1_valid = 1'b0; else r0_valid = 1'b0;
    @(negedge clk);
    chk("exec_no_rsp", rsp_valid, 1'b0);
    chk("exec_alu_op", alu_op, v.op);
    @(negedge clk);
    chk("resp_valid", rsp_valid, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_alu_x"}, alu_x, 0);
    chk({tag, "_alu_y"}, alu_y, 0);
    chk({tag, "_alu_op"}, alu_op, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_bus"}, {rsp_id, rsp_z, rsp_equal, rsp_overflow, rsp_zero, rsp_err}, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    logic [W+2:0] a;
    bit exp_id;

    vecs[0] = '{1'b0, 32'd5,          32'd3,          4'b0101, 32'd8,          1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_0000,  32'h00FF_00FF,  4'b0000, 32'h00FF_0000,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h7FFF_FFFF,  32'd1,          4'b0101, 32'h8000_0000,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_1234,  32'h0000_1234,  4'b0110, 32'd0,          1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'd7,          32'd7,          4'b0100, 32'd0,          1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 32'd1,          32'd4,          4'b1000, 32'h10,         1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'h8000_0000,  32'd1,          4'b0110, 32'h7FFF_FFFF,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 32'd0,          32'd0,          4'b1111, 32'd0,          1'b1, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 32'd3,          32'd5,          4'b1011, 32'd0,          1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9] = '{1'b1, 32'h0000_00F0,  32'h0000_000F,  4'b0001, 32'hFF,         1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    tb_last = 1'b1;
    @(negedge clk);
    chk("idle_r0_ready", r0_ready, 1'b0);
    chk("idle_r1_ready", r1_ready, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_single(vecs[i]);

    // Both requesters valid continuously: grants must alternate.
    drive_req(1'b0, $urandom, $urandom, 4'b0000);
    drive_req(1'b1, $urandom, $urandom, 4'b0001);
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_id = !tb_last;
      @(negedge clk);
      chk("rr_r0_ready", r0_ready, exp_id == 1'b0);
      chk("rr_r1_ready", r1_ready, exp_id == 1'b1);
      a = exp_id ? alu_ref(r1_x, r1_y, r1_op) : alu_ref(r0_x, r0_y, r0_op);
      push_exp(exp_id, a[W+2:3], a[2], a[1], a[0], 1'b0);
      tb_last = exp_id;
      @(posedge clk); #1;
      if (exp_id) drive_req(1'b1, $urandom, $urandom, 4'b0001);
      else        drive_req(1'b0, $urandom, $urandom, 4'b0000);
      @(negedge clk);
      chk("rr_exec_r0_ready", r0_ready, 1'b0);
      chk("rr_exec_r1_ready", r1_ready, 1'b0);
      @(negedge clk);
      chk("rr_resp_valid", rsp_valid, 1'b1);
      @(posedge clk); #1;
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;

    // Back-pressure: response held stable while the consumer stalls.
    drive_req(1'b1, 32'h1234, 32'h1234, 4'b0110);
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_r1_ready", r1_ready, 1'b1);
    push_exp(1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    tb_last = 1'b1;
    @(posedge clk); #1;
    r1_valid = 1'b0;
    drive_req(1'b0, 32'h55, 32'hAA, 4'b1100);
    @(negedge clk);
    chk("bp_exec_r0_ready", r0_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {rsp_valid, rsp_id, rsp_z, rsp_zero, rsp_equal}, {1'b1, 1'b1, 32'd0, 1'b1, 1'b1});
      chk("bp_r0_ready", r0_ready, 1'b0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", rsp_valid, 1'b1);
    @(posedge clk); #1;

    // Illegal op from the waiting r0 request.
    @(negedge clk);
    chk("ill_r0_ready", r0_ready, 1'b1);
    chk("ill_r1_ready", r1_ready, 1'b0);
    push_exp(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tb_last = 1'b0;
    @(posedge clk); #1;
    r0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ill_resp_valid", rsp_valid, 1'b1);
    @(posedge clk); #1;

    // Reset during EXEC discards the operation.
    drive_req(1'b1, 32'hDEAD, 32'hBEEF, 4'b0101);
    @(negedge clk);
    chk("rx_r1_ready", r1_ready, 1'b1);
    @(posedge clk); #1;
    r1_valid = 1'b0;
    @(negedge clk);
    chk("rx_alu_x_loaded", alu_x, 32'hDEAD);
    rst = 1'b1;
    #1;
    chk_all_zero("rx");
    @(posedge clk); #1;
    rst = 1'b0;
    tb_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rx_no_rsp", rsp_valid, 1'b0);
    end
    @(posedge clk); #1;
    drive_req(1'b0, 32'h0F0F, 32'h00FF, 4'b0010);
    drive_req(1'b1, 32'h1, 32'h2, 4'b0011);
    @(negedge clk);
    chk("rx_contend_r0", r0_ready, 1'b1);
    chk("rx_contend_r1", r1_ready, 1'b0);
    push_exp(1'b0, 32'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
    tb_last = 1'b0;
    @(posedge clk); #1;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rx_resp_valid", rsp_valid, 1'b1);
    @(posedge clk); #1;

    // After a fresh reset r1 alone is served, then r0 wins the contention.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tb_last = 1'b1;
    drive_req(1'b1, 32'h8000_0000, 32'd4, 4'b1010);
    @(negedge clk);
    chk("r1only_r1_ready", r1_ready, 1'b1);
    chk("r1only_r0_ready", r0_ready, 1'b0);
    push_exp(1'b1, 32'hF800_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tb_last = 1'b1;
    @(posedge clk); #1;
    drive_req(1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0111);
    drive_req(1'b1, 32'h100, 32'd4, 4'b1001);
    @(negedge clk);
    chk("r1only_exec_r0", r0_ready, 1'b0);
    @(negedge clk);
    chk("r1only_resp_valid", rsp_valid, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("next_r0_ready", r0_ready, 1'b1);
    chk("next_r1_ready", r1_ready, 1'b0);
    push_exp(1'b0, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tb_last = 1'b0;
    @(posedge clk); #1;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("next_resp_valid", rsp_valid, 1'b1);
    @(posedge clk); #1;

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
